// File: rtl/chunk_fetcher_if.sv
// chunk_fetcher_if: start/RAM-read/chunk-stream bundle for chunk_fetcher.
// slave is the fetcher side; master is the environment (controller, RAM, consumer).
interface chunk_fetcher_if #(
    parameter int AW = 10
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] addr_r;
    logic [31:0]   dout;
    logic          rd_en;
    logic [31:0]   chunk_out;
    logic          chunk_valid;
    logic          chunk_ready;
    logic          row_end;
    logic          frame_end;
    logic          busy;
    logic          done;

    modport slave (
        input  start, base_addr, dout, chunk_ready,
        output addr_r, rd_en, chunk_out, chunk_valid, row_end, frame_end, busy, done
    );

    modport master (
        output start, base_addr, dout, chunk_ready,
        input  addr_r, rd_en, chunk_out, chunk_valid, row_end, frame_end, busy, done
    );
endinterface

// File: rtl/chunk_fetcher.sv
// chunk_fetcher: streams one IMG_W x IMG_H frame of 32-bit chunks from a 1-cycle
// latency tensor RAM through a 2-entry output FIFO to the sliding-window consumer.
module chunk_fetcher #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input logic            clk,
    input logic            reset,
    chunk_fetcher_if.slave bus
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [AW-1:0] idx;
    logic [CW-1:0] col;
    logic          in_flight;
    logic          pend_row;
    logic          pend_frame;
    logic [31:0]   data_q [2];
    logic          row_q [2];
    logic          frame_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          valid;
    logic          pop;
    logic          issue;
    logic [1:0]    credit;
    logic [AW:0]   sum;
    logic [AW:0]   wrapped;

    always_comb begin
        valid   = count != 2'd0;
        pop     = valid && bus.chunk_ready;
        // Slots held after this edge; counting the pop keeps reads flowing every cycle.
        credit  = count - {1'b0, pop} + {1'b0, in_flight};
        issue   = state == FETCH && credit < 2'd2;
        sum     = {1'b0, base} + {1'b0, idx};
        wrapped = sum - DEPTH_W;
    end

    assign bus.rd_en       = issue;
    assign bus.addr_r      = sum >= DEPTH_W ? wrapped[AW-1:0] : sum[AW-1:0];
    assign bus.chunk_valid = valid;
    assign bus.chunk_out   = data_q[rd_ptr];
    assign bus.row_end     = valid && row_q[rd_ptr];
    assign bus.frame_end   = valid && frame_q[rd_ptr];
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            idx        <= '0;
            col        <= '0;
            in_flight  <= 1'b0;
            pend_row   <= 1'b0;
            pend_frame <= 1'b0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            row_q[0]   <= 1'b0;
            row_q[1]   <= 1'b0;
            frame_q[0] <= 1'b0;
            frame_q[1] <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
        end else begin
            count     <= credit;
            in_flight <= issue;
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (in_flight) begin
                data_q[wr_ptr]  <= bus.dout;
                row_q[wr_ptr]   <= pend_row;
                frame_q[wr_ptr] <= pend_frame;
                wr_ptr          <= ~wr_ptr;
            end
            // Tags travel with the read so they line up with the returning data.
            if (issue) begin
                pend_row   <= col == LAST_COL;
                pend_frame <= idx == LAST_IDX;
                idx        <= idx + AW'(1);
                col        <= col == LAST_COL ? '0 : col + CW'(1);
            end
            case (state)
                IDLE: if (bus.start) begin
                    base  <= bus.base_addr;
                    idx   <= '0;
                    col   <= '0;
                    state <= FETCH;
                end
                FETCH: if (issue && idx == LAST_IDX) state <= DRAIN;
                DRAIN: if (credit == 2'd0) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
